// File: rtl/xbus_uart_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and FSM encodings for xbus_uart.
package xbus_uart_pkg;

    localparam logic [4:0] OFF_TXDATA = 5'h00;
    localparam logic [4:0] OFF_RXDATA = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_DIV    = 5'h10;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_BUSY   = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam int CTRL_RX_POP = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_LOOP   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // A divisor of zero behaves as one cycle per bit.
    function automatic logic [15:0] eff_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO, 8-bit data, depth 2**AW; extra pointer bit separates full from empty.
module uart_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem_q [2**AW];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push_s;
    logic        do_pop_s;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Pointer and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < (1 << AW); i++) mem_q[i] <= 8'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q[AW-1:0]] <= din;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (do_pop_s) rptr_q <= rptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/xbus_uart.sv
// xbus-mapped 8N1 UART: TX FIFO, single RX holding register, programmable divisor.
// Define XBUS_UART_LOOPBACK_EN to add the CTRL bit2 internal loopback.
module xbus_uart
    import xbus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          TXF_AW      = 2,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xbus_as,
    input  logic        xbus_we,
    input  logic [3:0]  xbus_be,
    input  logic [31:0] xbus_addr,
    input  logic [31:0] xbus_wdata,
    output logic [31:0] xbus_rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, div_q, div_d;
    logic [2:0]  tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        tx_line_q, tx_line_d, uart_tx_q;
    logic [1:0]  rx_sync_q;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic        frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;
    logic        loop_q, loop_d;
    logic        sel_s, wr_s, wr_tx_s, wr_ctrl_s, wr_div_s, rx_pop_s, clr_s;
    logic        tx_pop_s, fifo_full_s, fifo_empty_s, tx_busy_s;
    logic        rx_s, rx_in_s, rx_ok_s, rx_bad_s;
    logic [7:0]  fifo_dout_s;
    logic [15:0] period_s, half_s;
    logic [4:0]  off_s;
    logic [5:0]  status_s;

    assign sel_s     = xbus_as && (xbus_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_s      = sel_s && xbus_we;
    assign off_s     = xbus_addr[4:0];
    assign wr_tx_s   = wr_s && (off_s == OFF_TXDATA) && xbus_be[0];
    assign wr_ctrl_s = wr_s && (off_s == OFF_CTRL) && xbus_be[0];
    assign wr_div_s  = wr_s && (off_s == OFF_DIV);
    assign rx_pop_s  = wr_ctrl_s && xbus_wdata[CTRL_RX_POP];
    assign clr_s     = wr_ctrl_s && xbus_wdata[CTRL_CLR];
    assign period_s  = eff_period(div_q);
    assign half_s    = eff_period({1'b0, period_s[15:1]});
    assign tx_busy_s = (tx_state_q != S_IDLE) || !fifo_empty_s;
    assign rx_s      = rx_sync_q[1];
    assign rx_in_s   = loop_q ? tx_line_q : uart_rx;
    assign uart_tx   = uart_tx_q;
    assign status_s  = {frame_err_q, rx_ovr_q, tx_ovf_q, rx_valid_q, tx_busy_s, fifo_full_s};

`ifdef XBUS_UART_LOOPBACK_EN
    assign loop_d = wr_ctrl_s ? xbus_wdata[CTRL_LOOP] : loop_q;

    // Loopback control bit.
    always_ff @(posedge clk) begin
        if (rst) loop_q <= 1'b0;
        else     loop_q <= loop_d;
    end
`else
    assign loop_d = 1'b0;
    assign loop_q = 1'b0;
`endif

    uart_fifo #(.AW(TXF_AW)) u_txf (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx_s),
        .pop   (tx_pop_s),
        .din   (xbus_wdata[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // TX next state: every state lasts P cycles; STOP chains straight into START when data waits.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = fifo_dout_s;
                    tx_cnt_d   = period_s - 16'd1;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_idx_d   = 3'd0;
                    tx_cnt_d   = period_s - 16'd1;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = period_s - 16'd1;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    if (!fifo_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_d = fifo_dout_s;
                        tx_cnt_d   = period_s - 16'd1;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // RX next state: half-period start check, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_ok_s    = 1'b0;
        rx_bad_s   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_d   = half_s - 16'd1;
                    rx_state_d = S_START;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_idx_d   = 3'd0;
                        rx_cnt_d   = period_s - 16'd1;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_cnt_d   = period_s - 16'd1;
                    if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_ok_s    = rx_s;
                    rx_bad_s   = !rx_s;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Holding register, sticky flags and divisor; a set in the same cycle as a clear wins.
    always_comb begin
        rx_valid_d  = rx_valid_q;
        rx_byte_d   = rx_byte_q;
        rx_ovr_d    = rx_ovr_q & ~clr_s;
        frame_err_d = (frame_err_q & ~clr_s) | rx_bad_s;
        tx_ovf_d    = (tx_ovf_q & ~clr_s) | (wr_tx_s && fifo_full_s && !tx_pop_s);
        div_d       = div_q;
        if (rx_pop_s) rx_valid_d = 1'b0;
        else          rx_valid_d = rx_valid_q;
        if (rx_ok_s && (!rx_valid_q || rx_pop_s)) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_ok_s) begin
            rx_ovr_d = 1'b1;
        end else begin
            rx_byte_d = rx_byte_q;
        end
        if (wr_div_s && xbus_be[0]) div_d[7:0]  = xbus_wdata[7:0];
        else                        div_d[7:0]  = div_q[7:0];
        if (wr_div_s && xbus_be[1]) div_d[15:8] = xbus_wdata[15:8];
        else                        div_d[15:8] = div_q[15:8];
    end

    // State registers; the output pin is idle-high and forced high in loopback.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= 16'd0;
            tx_idx_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_line_q   <= 1'b1;
            uart_tx_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_idx_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
            rx_sync_q   <= 2'b11;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            div_q       <= DEFAULT_DIV;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            uart_tx_q   <= tx_line_d | loop_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_sync_q   <= {rx_sync_q[0], rx_in_s};
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_ovf_q    <= tx_ovf_d;
            div_q       <= div_d;
        end
    end

    // Side-effect-free read mux.
    always_comb begin
        xbus_rdata = 32'd0;
        if (sel_s) begin
            case (off_s)
                OFF_RXDATA: xbus_rdata = {23'd0, rx_valid_q, rx_byte_q};
                OFF_STATUS: xbus_rdata = {26'd0, status_s};
                OFF_CTRL:   xbus_rdata = {29'd0, loop_q, 2'b00};
                OFF_DIV:    xbus_rdata = {16'd0, div_q};
                default:    xbus_rdata = 32'd0;
            endcase
        end else begin
            xbus_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_xbus_uart.sv
// Directed self-checking bench for xbus_uart (default build and XBUS_UART_LOOPBACK_EN build).
module tb_xbus_uart;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h00;
    localparam logic [31:0] A_RX = BASE + 32'h04;
    localparam logic [31:0] A_ST = BASE + 32'h08;
    localparam logic [31:0] A_CT = BASE + 32'h0C;
    localparam logic [31:0] A_DV = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst, xbus_as, xbus_we, uart_rx, uart_tx;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr, xbus_wdata, xbus_rdata, rdv;
    logic [7:0]  txb [0:7];
    int          n_vec = 0;
    int          n_err = 0;
    int          guard;
    logic        pin_ok;

    always #5 clk = ~clk;

    xbus_uart dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (xbus_as),
        .xbus_we    (xbus_we),
        .xbus_be    (xbus_be),
        .xbus_addr  (xbus_addr),
        .xbus_wdata (xbus_wdata),
        .xbus_rdata (xbus_rdata),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        xbus_addr = a;
        xbus_we   = 1'b0;
        #1;
        d = xbus_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        xbus_addr  = a;
        xbus_wdata = d;
        xbus_be    = be;
        xbus_we    = 1'b1;
        tick(1);
        xbus_we    = 1'b0;
    endtask

    // Checks uart_tx at mid-bit of nframes back-to-back frames from txb[]; busy must drop after the last stop.
    task automatic tx_stream(input int nframes, input bit wait_fall, input int div);
        int          first;
        int          g;
        logic        eb;
        logic [31:0] st;
        first = 0;
        if (wait_fall) begin
            g = 0;
            while (uart_tx !== 1'b0 && g < 200) begin
                tick(1);
                g++;
            end
            chk("tx_start_seen", {31'd0, uart_tx}, 32'd0);
        end else begin
            first = 1;
        end
        tick(div / 2);
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < 10; b++) begin
                if (f == 0 && b < first) continue;
                eb = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : txb[f][b-1]);
                chk($sformatf("tx_f%0d_b%0d", f, b), {31'd0, uart_tx}, {31'd0, eb});
                if (f == nframes - 1 && b == 9) begin
                    rd(A_ST, st);
                    chk("tx_busy_in_stop", {31'd0, st[1]}, 32'd1);
                end
                tick(div);
            end
        end
        rd(A_ST, st);
        chk("tx_busy_after", {31'd0, st[1]}, 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stopb);
        uart_rx = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(8);
        end
        uart_rx = stopb;
        tick(8);
        uart_rx = 1'b1;
        tick(16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; xbus_as = 1'b1; xbus_we = 1'b0; xbus_be = 4'h0;
        xbus_addr = 32'd0; xbus_wdata = 32'd0; uart_rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        rd(A_ST, rdv); chk("reset_status", rdv, 32'h0);
        rd(A_DV, rdv); chk("reset_div", rdv, 32'd434);
        rd(A_RX, rdv); chk("reset_rxdata", rdv, 32'h0);

        // Divisor byte enables: only the low byte of 0x01B2 is replaced.
        wr(A_DV, 32'h0000_ABCD, 4'b0001);
        rd(A_DV, rdv); chk("div_be0", rdv, 32'h0000_01CD);
        wr(A_DV, 32'd4, 4'b0011);
        rd(A_DV, rdv); chk("div_4", rdv, 32'd4);

        // Single frame 0x55 at 4 cycles per bit.
        txb[0] = 8'h55;
        wr(A_TX, 32'h55, 4'b0001);
        tx_stream(1, 1'b1, 4);

        // Six writes on consecutive cycles: one popped, four queued, sixth dropped.
        for (int i = 0; i < 5; i++) txb[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 6; i++) begin
            xbus_addr = A_TX; xbus_be = 4'b0001; xbus_we = 1'b1;
            xbus_wdata = 32'(8'h11 * (i + 1));
            tick(1);
        end
        xbus_we = 1'b0;
        rd(A_ST, rdv); chk("burst_status", rdv, 32'h0B);
        tx_stream(5, 1'b0, 4);
        rd(A_ST, rdv); chk("ovf_sticky", rdv, 32'h08);
        wr(A_CT, 32'h2, 4'b0001);
        rd(A_ST, rdv); chk("ovf_cleared", rdv, 32'h0);

        // Reset in the middle of a frame.
        wr(A_TX, 32'h00, 4'b0001);
        guard = 0;
        while (uart_tx !== 1'b0 && guard < 50) begin tick(1); guard++; end
        chk("rst_frame_started", {31'd0, uart_tx}, 32'd0);
        tick(6);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        rd(A_ST, rdv); chk("rst_mid_status", rdv, 32'h0);
        rd(A_DV, rdv); chk("rst_mid_div", rdv, 32'd434);
        rst = 1'b0;
        tick(10);
        chk("rst_tx_idle", {31'd0, uart_tx}, 32'd1);

        // Receive path at 8 cycles per bit.
        wr(A_DV, 32'd8, 4'b0011);
        rx_frame(8'hA3, 1'b1);
        rd(A_RX, rdv); chk("rx_a3", rdv, 32'h1A3);
        rx_frame(8'h5A, 1'b1);
        rd(A_RX, rdv); chk("rx_ovr_keep", rdv, 32'h1A3);
        rd(A_ST, rdv); chk("rx_ovr_status", rdv, 32'h14);
        wr(A_CT, 32'h3, 4'b0001);
        rd(A_RX, rdv); chk("rx_popped", rdv, 32'h0A3);
        rd(A_ST, rdv); chk("rx_clr_status", rdv, 32'h0);

        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(20);
        rd(A_ST, rdv); chk("glitch_status", rdv, 32'h0);
        rd(A_RX, rdv); chk("glitch_rxdata", rdv, 32'h0A3);

        rx_frame(8'h77, 1'b0);
        rd(A_ST, rdv); chk("ferr_status", rdv, 32'h20);
        rd(A_RX, rdv); chk("ferr_discard", rdv, 32'h0A3);
        wr(A_CT, 32'h2, 4'b0001);
        rd(A_ST, rdv); chk("ferr_cleared", rdv, 32'h0);

        rx_frame(8'h96, 1'b1);
        rd(A_RX, rdv); chk("rx_96", rdv, 32'h196);

        // Repeated reads must not consume the byte.
        for (int i = 0; i < 100; i++) begin
            rd((i % 2 == 0) ? A_RX : A_CT, rdv);
            tick(1);
        end
        rd(A_RX, rdv); chk("alias_reads", rdv, 32'h196);
        rd(BASE + 32'h24, rdv); chk("outside_window", rdv, 32'h0);
        rd(BASE + 32'h14, rdv); chk("reserved_off", rdv, 32'h0);
        rd(32'h0002_0004, rdv); chk("other_base", rdv, 32'h0);
        rd(A_TX, rdv); chk("txdata_reads0", rdv, 32'h0);
        xbus_as = 1'b0;
        rd(A_RX, rdv); chk("as_low", rdv, 32'h0);
        xbus_as = 1'b1;

`ifdef XBUS_UART_LOOPBACK_EN
        wr(A_CT, 32'h1, 4'b0001);
        wr(A_CT, 32'h4, 4'b0001);
        rd(A_CT, rdv); chk("loop_ctrl", rdv, 32'h4);
        wr(A_TX, 32'h3C, 4'b0001);
        pin_ok = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (uart_tx !== 1'b1) pin_ok = 1'b0;
        end
        chk("loop_pin_high", {31'd0, pin_ok}, 32'd1);
        rd(A_RX, rdv); chk("loop_rx", rdv, 32'h13C);
`else
        wr(A_CT, 32'h4, 4'b0001);
        rd(A_CT, rdv); chk("ctrl_reads0", rdv, 32'h0);
        wr(A_TX, 32'h3C, 4'b0001);
        guard = 0;
        while (uart_tx !== 1'b0 && guard < 50) begin tick(1); guard++; end
        chk("no_loop_pin", {31'd0, uart_tx}, 32'd0);
        tick(100);
        rd(A_RX, rdv); chk("no_loop_rx", rdv, 32'h196);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
